kodon_paketleyici: RTL

- Upstream feeder for the protein scoring stage.
- Takes two parallel nucleotide streams, one 2-bit base per stream per beat, and finds the reading frame on stream 1 by locating the start codon ATG.
- Once the frame is found, packs every three beats into a 6-bit codon pair (kodon1/kodon2) and hands it downstream with a valid/ready handshake.
- Re-enters frame search after a stop codon, a length limit, or end of sequence.

---
 rtl/kodon_pkg.sv | 24 ++
 rtl/kodon_paketleyici_if.sv | 27 ++
 rtl/kodon_pencere.sv | 52 +++++
 rtl/kodon_paketleyici.sv | 117 +++++++++++
 4 files changed

// File: rtl/kodon_pkg.sv
// Shared codon constants and stop-codon detection for the packer and the scoring stage.
package kodon_pkg;

    typedef enum logic [1:0] {
        BAZ_A = 2'b00,
        BAZ_T = 2'b01,
        BAZ_G = 2'b10,
        BAZ_C = 2'b11
    } baz_e;

    localparam logic [5:0] KODON_BASLA   = {BAZ_A, BAZ_T, BAZ_G};
    localparam logic [5:0] KODON_DUR_TAA = {BAZ_T, BAZ_A, BAZ_A};
    localparam logic [5:0] KODON_DUR_TAG = {BAZ_T, BAZ_A, BAZ_G};
    localparam logic [5:0] KODON_DUR_TGA = {BAZ_T, BAZ_G, BAZ_A};

    localparam logic [0:0] ARAMA   = 1'b0;
    localparam logic [0:0] KILITLI = 1'b1;

    function automatic logic dur_mu(input logic [5:0] kodon);
        return (kodon == KODON_DUR_TAA) || (kodon == KODON_DUR_TAG) ||
               (kodon == KODON_DUR_TGA);
    endfunction

endpackage

// File: rtl/kodon_paketleyici_if.sv
// Nucleotide-in / codon-out handshake bundle; slave is the packer, master the surroundings.
interface kodon_paketleyici_if;
    import kodon_pkg::*;

    logic [1:0]  nuk1;
    logic [1:0]  nuk2;
    logic        nuk_valid;
    logic        nuk_son;
    logic        nuk_ready;
    logic [5:0]  kodon1;
    logic [5:0]  kodon2;
    logic        kodon_valid;
    logic        kodon_ready;
    logic        cerceve_kilit;
    logic [15:0] arama_vurus;

    modport master (
        output nuk1, nuk2, nuk_valid, nuk_son, kodon_ready,
        input  nuk_ready, kodon1, kodon2, kodon_valid, cerceve_kilit, arama_vurus
    );

    modport slave (
        input  nuk1, nuk2, nuk_valid, nuk_son, kodon_ready,
        output nuk_ready, kodon1, kodon2, kodon_valid, cerceve_kilit, arama_vurus
    );

endinterface

// File: rtl/kodon_pencere.sv
// Three-base shift window with a shared fill/phase counter; latency 0 (next-window view), no backpressure.
module kodon_pencere
    import kodon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kaydir_i,
    input  logic       kilitli_i,
    input  logic       temizle_i,
    input  logic [1:0] nuk_i,
    output logic [5:0] pencere_d_o,
    output logic       tamam_o
);

    logic [5:0] pencere_q, pencere_d;
    logic [1:0] sayim_q, sayim_d;
    logic       tamam;

    // One counter serves both modes: fill (saturating at 3) while searching, phase 0..2 while locked.
    always_comb begin
        pencere_d = pencere_q;
        sayim_d   = sayim_q;
        tamam     = 1'b0;
        if (kaydir_i) begin
            pencere_d = {pencere_q[3:0], nuk_i};
            if (kilitli_i) begin
                tamam   = (sayim_q == 2'd2);
                sayim_d = tamam ? 2'd0 : sayim_q + 2'd1;
            end else begin
                tamam   = (sayim_q >= 2'd2);
                sayim_d = (sayim_q == 2'd3) ? 2'd3 : sayim_q + 2'd1;
            end
            if (temizle_i) begin
                sayim_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pencere_q <= '0;
            sayim_q   <= '0;
        end else begin
            pencere_q <= pencere_d;
            sayim_q   <= sayim_d;
        end
    end

    assign pencere_d_o = pencere_d;
    assign tamam_o     = tamam;

endmodule

// File: rtl/kodon_paketleyici.sv
// Finds the ATG frame on stream 1 and packs both streams into codon pairs; latency 1 beat-to-pair.
// Backpressure: a held, unconsumed pair deasserts nuk_ready until kodon_ready.
module kodon_paketleyici
    import kodon_pkg::*;
#(
    parameter int MAX_KODON = 1001,
    parameter int SAYAC_W   = 10
) (
    input logic               clk,
    input logic               rst_n,
    kodon_paketleyici_if.slave bus
);

    logic [0:0]         durum_q, durum_d;
    logic [SAYAC_W-1:0] sayac_q, sayac_d, sayac_yeni;
    logic [15:0]        vurus_q, vurus_d;
    logic [5:0]         kodon1_q, kodon1_d, kodon2_q, kodon2_d;
    logic               valid_q, valid_d;
    logic               kabul, yayin, temizle, kilitli;
    logic [5:0]         p1_d, p2_d;
    logic               tamam1, tamam2;

    assign bus.nuk_ready = rst_n && (!valid_q || bus.kodon_ready);
    assign kabul         = bus.nuk_valid && bus.nuk_ready;
    assign kilitli       = (durum_q == KILITLI);

    kodon_pencere u_pencere1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .kaydir_i   (kabul),
        .kilitli_i  (kilitli),
        .temizle_i  (temizle),
        .nuk_i      (bus.nuk1),
        .pencere_d_o(p1_d),
        .tamam_o    (tamam1)
    );

    kodon_pencere u_pencere2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .kaydir_i   (kabul),
        .kilitli_i  (kilitli),
        .temizle_i  (temizle),
        .nuk_i      (bus.nuk2),
        .pencere_d_o(p2_d),
        .tamam_o    (tamam2)
    );

    always_comb begin
        durum_d    = durum_q;
        sayac_d    = sayac_q;
        vurus_d    = vurus_q;
        kodon1_d   = kodon1_q;
        kodon2_d   = kodon2_q;
        valid_d    = valid_q && !bus.kodon_ready;
        yayin      = 1'b0;
        temizle    = 1'b0;
        sayac_yeni = sayac_q + 1'b1;
        if (kabul) begin
            if (durum_q == ARAMA) begin
                if (vurus_q != 16'hFFFF) begin
                    vurus_d = vurus_q + 16'd1;
                end
                if (tamam1 && tamam2 && (p1_d == KODON_BASLA)) begin
                    yayin      = 1'b1;
                    sayac_yeni = SAYAC_W'(1);
                    durum_d    = KILITLI;
                end
            end else if (tamam1 && tamam2) begin
                yayin = 1'b1;
                if (dur_mu(p1_d)) begin
                    durum_d = ARAMA;
                end
            end
            if (yayin) begin
                kodon1_d = p1_d;
                kodon2_d = p2_d;
                valid_d  = 1'b1;
                temizle  = 1'b1;
                sayac_d  = sayac_yeni;
                if (sayac_yeni == SAYAC_W'(MAX_KODON)) begin
                    durum_d = ARAMA;
                end
            end
            // End of sequence wins over everything else; any partial codon is dropped.
            if (bus.nuk_son) begin
                durum_d = ARAMA;
                temizle = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum_q  <= ARAMA;
            sayac_q  <= '0;
            vurus_q  <= '0;
            kodon1_q <= '0;
            kodon2_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            sayac_q  <= sayac_d;
            vurus_q  <= vurus_d;
            kodon1_q <= kodon1_d;
            kodon2_q <= kodon2_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.kodon1        = kodon1_q;
    assign bus.kodon2        = kodon2_q;
    assign bus.kodon_valid   = valid_q;
    assign bus.cerceve_kilit = kilitli;
    assign bus.arama_vurus   = vurus_q;

endmodule
